// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b datapath and L2 arbiter types.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;
    typedef enum logic [1:0] {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D, ARB_RELEASE} lc3b_arb_state;
    typedef enum logic {GRANT_I, GRANT_D} lc3b_grant;
endpackage

// File: rtl/arb_priority_select.sv
// arb_priority_select: picks the winner between I and D line requests.
//   in  i_req, d_req    pending requests
//   in  last_grant      side served most recently
//   out grant_i/grant_d one-hot winner (both 0 when nothing pending)
//   out conflict        both sides requesting
// ARB_ROUND_ROBIN_EN: alternate on conflicts, else D always wins.
module arb_priority_select
    import lc3b_types::*;
(
    input  logic      i_req,
    input  logic      d_req,
    input  lc3b_grant last_grant,
    output logic      grant_i,
    output logic      grant_d,
    output logic      conflict
);
`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        conflict = i_req & d_req;
        grant_d  = d_req & (~i_req | (last_grant == GRANT_I));
        grant_i  = i_req & ~grant_d;
    end
`else
    logic unused_last_grant;
    always_comb begin
        unused_last_grant = last_grant;
        conflict          = i_req & d_req;
        grant_d           = d_req;
        grant_i           = i_req & ~grant_d;
    end
`endif
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the L2 port between the I-cache and D-cache miss paths.
//   clk, rst_n (async, active-low)
//   i_read/i_address -> i_rdata/i_resp           I-cache side
//   d_read/d_write/d_address/d_wdata -> d_rdata/d_resp   D-cache side
//   l2_read/l2_write/l2_address/l2_wdata <- l2_rdata/l2_resp   L2 side
//   arb_conflict: pulse when an IDLE grant is made with both sides requesting
// Conflict policy set by ARB_ROUND_ROBIN_EN in arb_priority_select.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              arb_conflict
);
    lc3b_arb_state state_q, state_d;
    lc3b_grant     last_grant_q, last_grant_d;
    logic          d_req, sel_i, sel_d, both_req, serve_i, serve_d;

    always_comb d_req = d_read | d_write;

    arb_priority_select u_sel (
        .i_req      (i_read),
        .d_req      (d_req),
        .last_grant (last_grant_q),
        .grant_i    (sel_i),
        .grant_d    (sel_d),
        .conflict   (both_req)
    );

    always_comb begin
        serve_i = state_q == ARB_SERVE_I;
        serve_d = state_q == ARB_SERVE_D;
    end

    // RELEASE looks only at the side not just served: that side's request is still stale.
    always_comb begin
        last_grant_d = ((serve_i | serve_d) & l2_resp) ? (serve_d ? GRANT_D : GRANT_I) : last_grant_q;
        case (state_q)
            ARB_IDLE:    state_d = sel_d ? ARB_SERVE_D : sel_i ? ARB_SERVE_I : ARB_IDLE;
            ARB_SERVE_I,
            ARB_SERVE_D: state_d = l2_resp ? ARB_RELEASE : state_q;
            default:     state_d = (last_grant_q == GRANT_I) ? (d_req ? ARB_SERVE_D : ARB_IDLE)
                                                             : (i_read ? ARB_SERVE_I : ARB_IDLE);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Outputs decode from state only, so reset clears them the moment rst_n falls.
    always_comb begin
        l2_read      = serve_i | (serve_d & d_read & ~d_write);
        l2_write     = serve_d & d_write;
        l2_address   = serve_i ? i_address : serve_d ? d_address : '0;
        l2_wdata     = serve_d ? d_wdata : '0;
        i_resp       = serve_i & l2_resp;
        d_resp       = serve_d & l2_resp;
        i_rdata      = l2_rdata;
        d_rdata      = l2_rdata;
        arb_conflict = rst_n & (state_q == ARB_IDLE) & both_req;
    end
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed scenarios against a transaction-level arbiter model.
module tb_l2_arbiter;
    logic         clk = 0, rst_n = 0;
    logic         i_read = 0, d_read = 0, d_write = 0, l2_resp = 0;
    logic [15:0]  i_address = 0, d_address = 0, l2_address;
    logic [127:0] d_wdata = 0, l2_rdata = 0, i_rdata, d_rdata, l2_wdata;
    logic         i_resp, d_resp, l2_read, l2_write, arb_conflict;

    always #5 clk = ~clk;

    l2_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
        .l2_rdata(l2_rdata), .l2_resp(l2_resp), .arb_conflict(arb_conflict)
    );

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner 0=none 1=I 2=D; skip = side whose request is invisible this cycle.
    int owner = 0, skip = 0, last = 1;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = 0; skip = 0; last = 1;
        end else if (owner != 0) begin
            if (l2_resp) begin last = owner; skip = owner; owner = 0; end
        end else begin
            bit vi, vd;
            vi = i_read && skip != 1;
            vd = (d_read || d_write) && skip != 2;
            skip = 0;
            owner = (vi && vd) ? ((RR && last == 2) ? 1 : 2) : vd ? 2 : vi ? 1 : 0;
        end
    end

    int code = 0, conf_cnt = 0, iresp_cnt = 0, dresp_cnt = 0;
    bit busy_prev = 0, i_done = 0, d_done = 0;
    logic [15:0]  cap_addr = 0;
    logic [127:0] cap_wdata = 0;

    always @(negedge clk) begin
        chk("l2_read", 128'(l2_read), 128'((owner == 1) || (owner == 2 && d_read && !d_write)));
        chk("l2_write", 128'(l2_write), 128'(owner == 2 && d_write));
        chk("l2_address", 128'(l2_address), 128'(owner == 1 ? i_address : owner == 2 ? d_address : 16'h0));
        chk("l2_wdata", l2_wdata, owner == 2 ? d_wdata : 128'h0);
        chk("i_resp", 128'(i_resp), 128'(owner == 1 && l2_resp));
        chk("d_resp", 128'(d_resp), 128'(owner == 2 && l2_resp));
        chk("arb_conflict", 128'(arb_conflict),
            128'(rst_n && owner == 0 && skip == 0 && i_read && (d_read || d_write)));
        chk("i_rdata", i_rdata, l2_rdata);
        chk("d_rdata", d_rdata, l2_rdata);
        if (rst_n) begin
            if (i_resp) begin i_done = 1; iresp_cnt++; end
            if (d_resp) begin d_done = 1; dresp_cnt++; end
            if (arb_conflict) conf_cnt++;
            if ((l2_read || l2_write) && !busy_prev) begin
                code = code * 10 + ((l2_address == d_address && (d_read || d_write)) ? 2 : 1);
                if (l2_write) begin cap_addr = l2_address; cap_wdata = l2_wdata; end
            end
            busy_prev = l2_read || l2_write;
        end else busy_prev = 0;
    end

    // I-cache agent: holds each request until i_resp (one cycle longer when i_stale).
    logic [15:0] iq[$];
    bit i_stale = 0, i_hold = 0;
    always @(posedge clk) begin
        #1;
        if (i_hold) begin i_hold = 0; i_read = 0; end
        else if (i_done) begin
            i_done = 0;
            void'(iq.pop_front());
            if (i_stale) i_hold = 1; else i_read = 0;
        end
        if (!i_read && iq.size() > 0) begin i_read = 1; i_address = iq[0]; end
    end

    // D-cache agent: presents the next queued request right after d_resp.
    typedef struct {bit w; logic [15:0] a; logic [127:0] d;} dreq_t;
    dreq_t dq[$];
    always @(posedge clk) begin
        #1;
        if (d_done) begin d_done = 0; void'(dq.pop_front()); d_read = 0; d_write = 0; end
        if (!d_read && !d_write && dq.size() > 0) begin
            d_write = dq[0].w; d_read = !dq[0].w; d_address = dq[0].a; d_wdata = dq[0].d;
        end
    end

    // L2 agent: responds for one cycle in the lat-th cycle of a request.
    int lat = 1, cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n || l2_resp) begin l2_resp = 0; cnt = 0; end
        else if (l2_read || l2_write) begin
            cnt++;
            if (cnt >= lat) begin l2_resp = 1; l2_rdata = {8{l2_address ^ 16'h5a5a}}; end
        end else cnt = 0;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || i_read || d_read || d_write || l2_read || l2_write) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin errs++; $display("FAIL %s: idle timeout got busy expected idle", name); end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
    endtask

    task automatic clr();
        code = 0; conf_cnt = 0; iresp_cnt = 0; dresp_cnt = 0;
    endtask

    initial begin
        // Reset with I request held, then grant one cycle after release.
        lat = 2;
        iq.push_back(16'h1230);
        repeat (3) @(negedge clk);
        chk("rst_l2_read", 128'(l2_read), 128'(0));
        chk("rst_l2_address", 128'(l2_address), 128'(0));
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        chk("idle_l2_read", 128'(l2_read), 128'(0));
        @(negedge clk);
        chk("grant_l2_read", 128'(l2_read), 128'(1));
        chk("grant_l2_address", 128'(l2_address), 128'(16'h1230));
        wait_idle("s1");
        chk("s1_order", 128'(code), 128'(1));

        // Single D writeback, L2 answers in its 5th cycle.
        clr(); lat = 5;
        dq.push_back('{1'b1, 16'h4440, {16{8'hA5}}});
        wait_idle("s2");
        chk("s2_order", 128'(code), 128'(2));
        chk("s2_d_resp_cnt", 128'(dresp_cnt), 128'(1));
        chk("s2_i_resp_cnt", 128'(iresp_cnt), 128'(0));
        chk("s2_addr", 128'(cap_addr), 128'(16'h4440));
        chk("s2_wdata", cap_wdata, {16{8'hA5}});

        // Simultaneous streams from reset: D first, then strict alternation.
        do_reset(); clr(); lat = 1;
        for (int k = 0; k < 3; k++) begin
            iq.push_back(16'h3000 + 16'(k * 16));
            dq.push_back('{1'b0, 16'h5000 + 16'(k * 16), 128'h0});
        end
        wait_idle("s3");
        chk("s3_order", 128'(code), 128'(212121));
        chk("s3_conflicts", 128'(conf_cnt), 128'(1));

        // Stale I request lingering in RELEASE must not be regranted.
        clr(); lat = 2; i_stale = 1;
        iq.push_back(16'h2220);
        wait_idle("s4");
        i_stale = 0;
        chk("s4_order", 128'(code), 128'(1));
        chk("s4_i_resp_cnt", 128'(iresp_cnt), 128'(1));

        // Conflict after a D grant: policy dependent.
        lat = 1;
        dq.push_back('{1'b1, 16'h6660, 128'h1});
        wait_idle("s5a");
        clr();
        iq.push_back(16'h1110);
        dq.push_back('{1'b0, 16'h6670, 128'h0});
        wait_idle("s5");
        chk("s5_order", 128'(code), 128'(RR ? 12 : 21));
        chk("s5_conflicts", 128'(conf_cnt), 128'(1));

        // Spurious l2_resp while idle is ignored.
        clr();
        @(posedge clk); #2 l2_resp = 1;
        @(negedge clk);
        chk("spur_i_resp", 128'(i_resp), 128'(0));
        chk("spur_d_resp", 128'(d_resp), 128'(0));
        repeat (3) @(negedge clk);
        chk("spur_order", 128'(code), 128'(0));

        // Reset during SERVE_D: request drops at once, regranted afterwards.
        clr(); lat = 20;
        dq.push_back('{1'b1, 16'h7770, {8{16'hBEEF}}});
        begin
            int n = 0;
            while (!l2_write && n < 50) begin @(negedge clk); n++; end
            checks++;
            if (n >= 50) begin errs++; $display("FAIL s7_wait: got no l2_write expected l2_write"); end
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("s7_async_l2_write", 128'(l2_write), 128'(0));
        chk("s7_async_d_resp", 128'(d_resp), 128'(0));
        lat = 2;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        wait_idle("s7");
        chk("s7_order", 128'(code), 128'(22));
        chk("s7_d_resp_cnt", 128'(dresp_cnt), 128'(1));
        chk("s7_conflicts", 128'(conf_cnt), 128'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
